// File: rtl/segment_reader.sv
// Seven-segment read-back: samples the multiplexed active-low anode/cathode lines,
// reports each digit once it has been stable, and keeps a packed image of every position.
module segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic                      ca,
    input  logic                      cb,
    input  logic                      cc,
    input  logic                      cd,
    input  logic                      ce,
    input  logic                      cf,
    input  logic                      cg,
    output logic                      digit_valid,
    output logic [2:0]                digit_pos,
    output logic [3:0]                digit_value,
    output logic                      digit_error,
    output logic [4*NUM_DIGITS-1:0]   digits_packed,
    output logic                      frame_done
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

    logic [NUM_DIGITS-1:0] an_reg, an_prev_reg;
    logic [6:0]            seg_reg, seg_prev_reg;
    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [NUM_DIGITS-1:0] seen_reg, seen_next;
    logic [3:0]            zero_cnt;
    logic                  selected;
    logic [2:0]            sel_pos;
    logic                  same;
    logic                  report;
    logic [3:0]            code;
    logic                  seen_full;

    // Input stage plus a copy of the previous sample for the stability compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            an_reg       <= '1;
            seg_reg      <= '1;
            an_prev_reg  <= '1;
            seg_prev_reg <= '1;
        end else begin
            an_reg       <= an;
            seg_reg      <= {ca, cb, cc, cd, ce, cf, cg};
            an_prev_reg  <= an_reg;
            seg_prev_reg <= seg_reg;
        end
    end

    always_comb begin
        zero_cnt = 4'd0;
        sel_pos  = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_reg[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                sel_pos  = 3'(i);
            end
        end
        selected = (zero_cnt == 4'd1);
        same     = (an_reg == an_prev_reg) && (seg_reg == seg_prev_reg);
    end

    always_comb begin
        case (seg_reg)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0000100: code = 4'h9;
            7'b1111111: code = 4'hA;
            default:    code = 4'hF;
        endcase
    end

    always_comb begin
        seen_next = seen_reg;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_pos == 3'(i)) seen_next[i] = 1'b1;
        end
        seen_full = &seen_next;
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        report     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (selected) begin
                    state_next = SETTLE;
                    cnt_next   = CW'(1);
                end
            end
            SETTLE: begin
                if (!selected) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!same) begin
                    cnt_next = CW'(1);
                end else if (cnt_reg >= CW'(STABLE_CYCLES - 1)) begin
                    cnt_next   = CW'(STABLE_CYCLES);
                    state_next = HELD;
                    report     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HELD: begin
                if (!selected) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!same) begin
                    state_next = SETTLE;
                    cnt_next   = CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The completing report's own bit is dropped so each frame starts empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_valid <= 1'b0;
            digit_error <= 1'b0;
            frame_done  <= 1'b0;
            digit_pos   <= 3'd0;
            digit_value <= 4'd0;
            seen_reg    <= '0;
        end else begin
            digit_valid <= report;
            digit_error <= report && (code == 4'hF);
            frame_done  <= report && seen_full;
            if (report) begin
                digit_pos   <= sel_pos;
                digit_value <= code;
                seen_reg    <= seen_full ? '0 : seen_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
            logic [3:0] entry_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    entry_reg <= 4'hA;
                end else if (report && (sel_pos == 3'(gi))) begin
                    entry_reg <= code;
                end
            end
            assign digits_packed[4*gi +: 4] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_segment_reader.sv
// Bench for segment_reader: directed vector table, a two-pass frame scan, then
// random stimulus checked against a run-length reference model.
module tb_segment_reader;
    localparam int ND = 4;
    localparam int SC = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic        ca, cb, cc, cd, ce, cf, cg;
    logic        digit_valid;
    logic [2:0]  digit_pos;
    logic [3:0]  digit_value;
    logic        digit_error;
    logic [15:0] digits_packed;
    logic        frame_done;

    segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clock(clock), .reset(reset), .an(an),
        .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg),
        .digit_valid(digit_valid), .digit_pos(digit_pos), .digit_value(digit_value),
        .digit_error(digit_error), .digits_packed(digits_packed), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        v;
        logic [2:0]  pos;
        logic [3:0]  val;
        logic        err;
        logic        fr;
        logic [15:0] pk;
    } vec_t;

    vec_t vecs[$];
    logic [6:0] pats[10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    int passed = 0;
    int total  = 0;
    int step_no = 0;

    // Reference model: a report happens when a selected sample has repeated SC times in a row.
    int          run_len;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_v, m_err, m_fr;
    logic [2:0]  m_pos;
    logic [3:0]  m_val;
    logic [15:0] m_pk;
    logic [3:0]  m_seen;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        logic [3:0] r;
        r = (s == 7'h7F) ? 4'hA : 4'hF;
        for (int k = 0; k < 10; k++) if (pats[k] == s) r = 4'(k);
        return r;
    endfunction

    task automatic model_reset();
        run_len = 0;
        m_an = '1; m_seg = '1;
        m_v = 0; m_err = 0; m_fr = 0;
        m_pos = 0; m_val = 0;
        m_pk = 16'hAAAA; m_seen = 0;
    endtask

    task automatic model_update(input logic [3:0] a, input logic [6:0] s);
        logic sel;
        int p;
        sel = ($countones(~a) == 1);
        m_v = 0; m_err = 0; m_fr = 0;
        if (!sel) run_len = 0;
        else if (run_len > 0 && a == m_an && s == m_seg) run_len++;
        else run_len = 1;
        m_an = a; m_seg = s;
        if (sel && run_len == SC) begin
            p = 0;
            for (int k = 0; k < ND; k++) if (!a[k]) p = k;
            m_v   = 1;
            m_pos = 3'(p);
            m_val = ref_decode(s);
            m_err = (m_val == 4'hF);
            m_pk[4*p +: 4] = m_val;
            m_seen[p] = 1'b1;
            if (&m_seen) begin
                m_fr = 1;
                m_seen = 0;
            end
        end
    endtask

    task automatic add(input int n, input logic r, input logic [3:0] a, input logic [6:0] s,
                       input logic v, input logic [2:0] pos, input logic [3:0] val,
                       input logic err, input logic fr, input logic [15:0] pk);
        vec_t e;
        e = '{rst: r, an: a, seg: s, v: v, pos: pos, val: val, err: err, fr: fr, pk: pk};
        repeat (n) vecs.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] a, input logic [6:0] s);
        reset = r;
        an = a;
        {ca, cb, cc, cd, ce, cf, cg} = s;
        @(posedge clock);
        #1;
        step_no++;
    endtask

    task automatic compare(input string name, input logic v, input logic [2:0] pos,
                           input logic [3:0] val, input logic err, input logic fr,
                           input logic [15:0] pk);
        total++;
        if ({digit_valid, digit_pos, digit_value, digit_error, frame_done, digits_packed} ===
            {v, pos, val, err, fr, pk})
            passed++;
        else
            $display("FAIL %s step %0d: got v=%b pos=%0d val=%h err=%b fd=%b packed=%h, want v=%b pos=%0d val=%h err=%b fd=%b packed=%h",
                     name, step_no, digit_valid, digit_pos, digit_value, digit_error, frame_done,
                     digits_packed, v, pos, val, err, fr, pk);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic [3:0] a, input logic [6:0] s);
        drive(r, a, s);
        if (r) model_reset();
        compare("model", m_v, m_pos, m_val, m_err, m_fr, m_pk);
        if (!r) model_update(a, s);
    endtask

    initial begin
        int strobes, frames, hold;
        logic [3:0] ra;
        logic [6:0] rs;
        logic       rr;

        reset = 1'b1; an = '1; {ca, cb, cc, cd, ce, cf, cg} = 7'h7F;
        model_reset();

        // reset
        add(1, 1, 4'hF, 7'h7F, 0, 0, 4'h0, 0, 0, 16'hAAAA);
        // digit 0 on pos 0 held steady
        add(4, 0, 4'hE, 7'h01, 0, 0, 4'h0, 0, 0, 16'hAAAA);
        add(1, 0, 4'hE, 7'h01, 1, 0, 4'h0, 0, 0, 16'hAAA0);
        add(2, 0, 4'hE, 7'h01, 0, 0, 4'h0, 0, 0, 16'hAAA0);
        // glitch restart on pos 1
        add(3, 0, 4'hD, 7'h12, 0, 0, 4'h0, 0, 0, 16'hAAA0);
        add(1, 0, 4'hD, 7'h00, 0, 0, 4'h0, 0, 0, 16'hAAA0);
        add(4, 0, 4'hD, 7'h12, 0, 0, 4'h0, 0, 0, 16'hAAA0);
        add(1, 0, 4'hD, 7'h12, 1, 1, 4'h2, 0, 0, 16'hAA20);
        // two anodes low: ignored
        add(6, 0, 4'hC, 7'h01, 0, 1, 4'h2, 0, 0, 16'hAA20);
        // unrecognised pattern then blank on pos 2
        add(4, 0, 4'hB, 7'h55, 0, 1, 4'h2, 0, 0, 16'hAA20);
        add(1, 0, 4'hB, 7'h55, 1, 2, 4'hF, 1, 0, 16'hAF20);
        add(4, 0, 4'hB, 7'h7F, 0, 2, 4'hF, 0, 0, 16'hAF20);
        add(1, 0, 4'hB, 7'h7F, 1, 2, 4'hA, 0, 0, 16'hAA20);
        // reset on the third stable sample, then no report yet
        add(2, 0, 4'h7, 7'h06, 0, 2, 4'hA, 0, 0, 16'hAA20);
        add(1, 1, 4'h7, 7'h06, 0, 0, 4'h0, 0, 0, 16'hAAAA);
        add(3, 0, 4'h7, 7'h06, 0, 0, 4'h0, 0, 0, 16'hAAAA);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].an, vecs[k].seg);
            if (vecs[k].rst) model_reset();
            compare("vec", vecs[k].v, vecs[k].pos, vecs[k].val, vecs[k].err, vecs[k].fr, vecs[k].pk);
            if (!vecs[k].rst) model_update(vecs[k].an, vecs[k].seg);
        end

        // two full scans of positions 0..3 showing 1,2,3,4
        strobes = 0;
        frames = 0;
        for (int scan = 0; scan < 2; scan++) begin
            for (int p = 0; p < ND; p++) begin
                repeat (6) begin
                    model_step(0, ~(4'b0001 << p), pats[p+1]);
                    if (digit_valid) strobes++;
                    if (frame_done) begin
                        frames++;
                        check_int("frame_with_pos3", {28'd0, digit_valid, digit_pos}, 32'h0000000B);
                    end
                end
            end
        end
        check_int("scan_strobes", strobes, 8);
        check_int("scan_frames", frames, 2);
        check_int("scan_packed", int'(digits_packed), 32'h4321);

        // randomized hold lengths, patterns and occasional resets
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = 4'hF;
                1:       ra = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'hC;
                default: ra = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                0:       rs = 7'h7F;
                1, 2:    rs = 7'($urandom);
                default: rs = pats[$urandom_range(0, 9)];
            endcase
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                rr = ($urandom_range(0, 59) == 0);
                model_step(rr, ra, rs);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
